// File: rtl/pipelined_color_mapper.sv
// Composites tiles, treasures and player sprites into RGB through a 3-register pipeline, 1 pixel/cycle, no stalls.
// Defining PLAYER_BLINK_EN blanks players whose blink bit is set while frame_cnt[3] is high.
module pipelined_color_mapper #(
   parameter int TILE        = 40,
   parameter int MAP_COLS    = 16,
   parameter int MAP_ROWS    = 12,
   parameter int NUM_PLAYERS = 2,
   parameter int HALF        = 20
) (
   input  logic                                  Clk,
   input  logic                                  Reset,
   input  logic                                  pix_valid_in,
   input  logic [9:0]                            DrawX,
   input  logic [9:0]                            DrawY,
   input  logic                                  frame_start,
   input  logic [NUM_PLAYERS-1:0][9:0]           player_X,
   input  logic [NUM_PLAYERS-1:0][9:0]           player_Y,
   input  logic [NUM_PLAYERS-1:0]                player_alive,
   input  logic [NUM_PLAYERS-1:0]                player_blink,
   input  logic [0:MAP_COLS*MAP_ROWS-1][3:0]     map_array,
   input  logic [0:MAP_COLS*MAP_ROWS-1][3:0]     treasure_array,
   output logic                                  pix_valid_out,
   output logic [7:0]                            Red,
   output logic [7:0]                            Green,
   output logic [7:0]                            Blue,
   output logic [5:0]                            frame_cnt
);

   localparam int NT = MAP_COLS * MAP_ROWS;
   localparam int IW = (NT > 1) ? $clog2(NT) : 1;
   localparam int TW = $clog2(TILE);
   localparam int PW = $clog2(2 * HALF);
   localparam logic [4:0] TRANSP = 5'h0f;
   localparam logic [4:0] GRASS  = 5'd1;

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Tile layer sprites: 1 box, 2 brick, 3 bomb (transparent outside the diamond), 4 explosion.
   function automatic logic [4:0] tile_rom(input logic [3:0] code, input logic [TW-1:0] xv,
                                           input logic [TW-1:0] yv);
      int x;
      int y;
      logic [4:0] c;
      x = int'(xv);
      y = int'(yv);
      c = TRANSP;
      case (code)
         4'd1:    c = (x < 2 || y < 2 || x >= TILE-2 || y >= TILE-2) ? 5'd4 : 5'd3;
         4'd2:    c = ((y % (TILE/4)) == TILE/4 - 1) ? 5'd6 : 5'd5;
         4'd3:    c = (iabs(x - TILE/2) + iabs(y - TILE/2) < (TILE*3)/8) ? 5'd7 : TRANSP;
         4'd4:    c = 5'd8;
         default: c = TRANSP;
      endcase
      return c;
   endfunction

   function automatic logic [4:0] treasure_rom(input logic [3:0] code, input logic [TW-1:0] xv,
                                               input logic [TW-1:0] yv);
      int x;
      int y;
      logic [4:0] c;
      x = int'(xv);
      y = int'(yv);
      c = TRANSP;
      case (code)
         4'd5:    c = (x >= TILE/4 && x < (3*TILE)/4 && y >= TILE/2 && y < (TILE*4)/5) ? 5'd9 : TRANSP;
         4'd6:    c = (iabs(x - TILE/2) + iabs(y - TILE/2 - 2) < (TILE*3)/10) ? 5'd10 : TRANSP;
         default: c = TRANSP;
      endcase
      return c;
   endfunction

   // Square body with a per-player transparent slot, so overlapping players stay distinguishable.
   function automatic logic [4:0] player_rom(input int p, input logic [PW-1:0] xv,
                                             input logic [PW-1:0] yv);
      int x;
      int y;
      logic body;
      logic hole;
      x = int'(xv);
      y = int'(yv);
      body = (x >= 2) && (x < 2*HALF - 2) && (y >= 2) && (y < 2*HALF - 2);
      hole = (y >= HALF - 4) && (y < HALF + 4) && (x >= 4 + 8*p) && (x < 12 + 8*p);
      return (body && !hole) ? 5'(11 + p) : TRANSP;
   endfunction

   function automatic logic [23:0] color_lut(input logic [4:0] idx);
      logic [23:0] c;
      case (idx)
         5'd1:    c = 24'h228B22;
         5'd3:    c = 24'hC08040;
         5'd4:    c = 24'h804020;
         5'd5:    c = 24'hB22222;
         5'd6:    c = 24'hC0C0C0;
         5'd7:    c = 24'h202020;
         5'd8:    c = 24'hFFA500;
         5'd9:    c = 24'h8B4513;
         5'd10:   c = 24'h8A2BE2;
         5'd11:   c = 24'h0000FF;
         5'd12:   c = 24'hFF0000;
         5'd13:   c = 24'h00FF00;
         5'd14:   c = 24'hFFFF00;
         default: c = 24'h000000;
      endcase
      return c;
   endfunction

   logic [5:0] frame_cnt_q;

   always_ff @(posedge Clk) begin
      if (!Reset)           frame_cnt_q <= 6'd0;
      else if (frame_start) frame_cnt_q <= frame_cnt_q + 6'd1;
   end

   assign frame_cnt = frame_cnt_q;

   logic [NUM_PLAYERS-1:0] blank_d;
`ifdef PLAYER_BLINK_EN
   assign blank_d = player_blink & {NUM_PLAYERS{frame_cnt_q[3]}};
`else
   logic unused_blink;
   assign unused_blink = ^player_blink;
   assign blank_d = '0;
`endif

   // ---------------- S1: tile coordinates, map fetch, player window hits
   logic [9:0]                       col_d, row_d;
   logic [TW-1:0]                    tx_d, ty_d;
   logic                             oom_d;
   logic [IW-1:0]                    idx_d;
   logic [NUM_PLAYERS-1:0][10:0]     dx_d, dy_d;
   logic [NUM_PLAYERS-1:0]           hit_d;
   logic [NUM_PLAYERS-1:0][PW-1:0]   pox_d, poy_d;

   assign col_d = DrawX / 10'(TILE);
   assign row_d = DrawY / 10'(TILE);
   assign tx_d  = TW'(DrawX % 10'(TILE));
   assign ty_d  = TW'(DrawY % 10'(TILE));
   assign oom_d = (col_d >= 10'(MAP_COLS)) || (row_d >= 10'(MAP_ROWS));
   assign idx_d = oom_d ? '0 : IW'(16'(row_d) * 16'(MAP_COLS) + 16'(col_d));

   // 11-bit offsets: a negative result sets bit 10 and fails the window test.
   always_comb begin
      dx_d  = '0;
      dy_d  = '0;
      hit_d = '0;
      pox_d = '0;
      poy_d = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         dx_d[p]  = {1'b0, DrawX} - {1'b0, player_X[p]} + 11'(HALF);
         dy_d[p]  = {1'b0, DrawY} - {1'b0, player_Y[p]} + 11'(HALF);
         hit_d[p] = !dx_d[p][10] && !dy_d[p][10] &&
                    (dx_d[p] < 11'(2*HALF)) && (dy_d[p] < 11'(2*HALF));
         pox_d[p] = dx_d[p][PW-1:0];
         poy_d[p] = dy_d[p][PW-1:0];
      end
   end

   logic                             v1_q, oom1_q;
   logic [3:0]                       tile1_q, tres1_q;
   logic [TW-1:0]                    tx1_q, ty1_q;
   logic [NUM_PLAYERS-1:0]           draw1_q;
   logic [NUM_PLAYERS-1:0][PW-1:0]   pox1_q, poy1_q;

   always_ff @(posedge Clk) begin
      if (!Reset) v1_q <= 1'b0;
      else        v1_q <= pix_valid_in;
   end

   always_ff @(posedge Clk) begin
      oom1_q  <= oom_d;
      tile1_q <= map_array[idx_d];
      tres1_q <= treasure_array[idx_d];
      tx1_q   <= tx_d;
      ty1_q   <= ty_d;
      draw1_q <= hit_d & player_alive & ~blank_d;
      pox1_q  <= pox_d;
      poy1_q  <= poy_d;
   end

   // ---------------- S2: sprite ROM lookups
   logic [4:0]                       tpix_d, trpix_d;
   logic [NUM_PLAYERS-1:0][4:0]      ppix_d;

   always_comb begin
      tpix_d  = tile_rom(tile1_q, tx1_q, ty1_q);
      trpix_d = treasure_rom(tres1_q, tx1_q, ty1_q);
      ppix_d  = '0;
      for (int p = 0; p < NUM_PLAYERS; p++)
         ppix_d[p] = draw1_q[p] ? player_rom(p, pox1_q[p], poy1_q[p]) : TRANSP;
   end

   logic                             v2_q, oom2_q;
   logic [3:0]                       tile2_q;
   logic [4:0]                       tpix2_q, trpix2_q;
   logic [NUM_PLAYERS-1:0][4:0]      ppix2_q;

   always_ff @(posedge Clk) begin
      if (!Reset) v2_q <= 1'b0;
      else        v2_q <= v1_q;
   end

   always_ff @(posedge Clk) begin
      oom2_q   <= oom1_q;
      tile2_q  <= tile1_q;
      tpix2_q  <= tpix_d;
      trpix2_q <= trpix_d;
      ppix2_q  <= ppix_d;
   end

   // ---------------- S3: layer priority and colour table
   logic [4:0]  sel_d;
   logic [23:0] rgb_d;

   always_comb begin
      sel_d = GRASS;
      case (tile2_q)
         4'd1, 4'd2, 4'd4: sel_d = tpix2_q;
         4'd3:             if (tpix2_q != TRANSP) sel_d = tpix2_q;
         4'd0:             if (trpix2_q != TRANSP) sel_d = trpix2_q;
         default:          sel_d = GRASS;
      endcase
      // Descending scan so the lowest-indexed opaque player is the last writer.
      for (int p = NUM_PLAYERS-1; p >= 0; p--)
         if (ppix2_q[p] != TRANSP) sel_d = ppix2_q[p];
      rgb_d = (v2_q && !oom2_q) ? color_lut(sel_d) : 24'h000000;
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         pix_valid_out <= 1'b0;
         Red           <= 8'h00;
         Green         <= 8'h00;
         Blue          <= 8'h00;
      end else begin
         pix_valid_out <= v2_q;
         Red           <= rgb_d[23:16];
         Green         <= rgb_d[15:8];
         Blue          <= rgb_d[7:0];
      end
   end

endmodule

// File: tb/tb_pipelined_color_mapper.sv
// Directed bench for pipelined_color_mapper: expected pixels are queued at drive time and popped 3 cycles later.
module tb_pipelined_color_mapper;

   localparam logic [23:0] C_GRASS  = 24'h228B22;
   localparam logic [23:0] C_BOX    = 24'hC08040;
   localparam logic [23:0] C_BOXE   = 24'h804020;
   localparam logic [23:0] C_BRICK  = 24'hB22222;
   localparam logic [23:0] C_MORTAR = 24'hC0C0C0;
   localparam logic [23:0] C_BOMB   = 24'h202020;
   localparam logic [23:0] C_EXPL   = 24'hFFA500;
   localparam logic [23:0] C_SHOE   = 24'h8B4513;
   localparam logic [23:0] C_POTION = 24'h8A2BE2;
   localparam logic [23:0] C_P0     = 24'h0000FF;
   localparam logic [23:0] C_P1     = 24'hFF0000;

   logic              Clk;
   logic              Reset;
   logic              pix_valid_in;
   logic [9:0]        DrawX, DrawY;
   logic              frame_start;
   logic [1:0][9:0]   player_X, player_Y;
   logic [1:0]        player_alive, player_blink;
   logic [0:191][3:0] map_a, tres_a;
   logic              pix_valid_out;
   logic [7:0]        Red, Green, Blue;
   logic [5:0]        frame_cnt;

   pipelined_color_mapper dut (
      .Clk(Clk), .Reset(Reset), .pix_valid_in(pix_valid_in), .DrawX(DrawX), .DrawY(DrawY),
      .frame_start(frame_start), .player_X(player_X), .player_Y(player_Y),
      .player_alive(player_alive), .player_blink(player_blink),
      .map_array(map_a), .treasure_array(tres_a),
      .pix_valid_out(pix_valid_out), .Red(Red), .Green(Green), .Blue(Blue),
      .frame_cnt(frame_cnt)
   );

   typedef struct {
      int          cyc;
      logic        vld;
      logic [23:0] rgb;
      string       tag;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;
   logic mon_en = 1'b0;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Nothing may come out valid unless a queued pixel is due this cycle.
   always @(negedge Clk) begin
      if (mon_en) begin
         if (sb.size() > 0 && sb[0].cyc + 3 < cyc) begin
            mon_e = sb.pop_front();
            chk({mon_e.tag, "_missed"}, 32'(cyc), 32'(mon_e.cyc + 3));
         end else if (sb.size() > 0 && sb[0].cyc + 3 == cyc) begin
            mon_e = sb.pop_front();
            chk({mon_e.tag, "_vld"}, 32'(pix_valid_out), 32'(mon_e.vld));
            chk({mon_e.tag, "_rgb"}, {8'h00, Red, Green, Blue}, {8'h00, mon_e.rgb});
         end else begin
            chk("idle_vld", 32'(pix_valid_out), 32'd0);
         end
      end
   end

   task automatic drive(input int x, input int y, input logic v, input logic [23:0] rgb,
                        input string tag);
      exp_t e;
      DrawX        = 10'(x);
      DrawY        = 10'(y);
      pix_valid_in = v;
      e.cyc = cyc;
      e.vld = v;
      e.rgb = v ? rgb : 24'h000000;
      e.tag = tag;
      sb.push_back(e);
      @(posedge Clk); #1;
   endtask

   task automatic pulse();
      frame_start = 1'b1;
      drive(0, 0, 1'b0, 24'h0, "fs");
      frame_start = 1'b0;
   endtask

   task automatic idle(input int n);
      pix_valid_in = 1'b0;
      repeat (n) begin
         @(posedge Clk); #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      Reset        = 1'b0;
      pix_valid_in = 1'b1;
      DrawX        = 10'd85;
      DrawY        = 10'd50;
      frame_start  = 1'b0;
      player_X     = '0;
      player_Y     = '0;
      player_alive = 2'b00;
      player_blink = 2'b00;
      map_a        = '0;
      tres_a       = '0;
      map_a[18]    = 4'd1;   // (2,1) box
      map_a[0]     = 4'd3;   // (0,0) bomb
      map_a[5]     = 4'd2;   // (5,0) brick
      map_a[6]     = 4'd4;   // (6,0) explosion
      tres_a[4]    = 4'd5;   // (4,0) shoe
      tres_a[7]    = 4'd6;   // (7,0) potion

      repeat (2) begin
         @(posedge Clk); #1;
         chk("rst_vld", 32'(pix_valid_out), 32'd0);
         chk("rst_rgb", {8'h00, Red, Green, Blue}, 32'd0);
         chk("rst_fc", 32'(frame_cnt), 32'd0);
      end

      mon_en = 1'b1;
      Reset  = 1'b1;
      drive(85, 50, 1'b1, C_BOX, "box");
      drive(125, 50, 1'b1, C_GRASS, "grass");
      drive(80, 40, 1'b1, C_BOXE, "box_edge");
      drive(0, 0, 1'b1, C_GRASS, "bomb_transp");
      drive(20, 20, 1'b1, C_BOMB, "bomb_opaque");
      drive(205, 9, 1'b1, C_MORTAR, "mortar");
      drive(205, 5, 1'b1, C_BRICK, "brick");
      drive(250, 10, 1'b1, C_EXPL, "expl");
      drive(180, 25, 1'b1, C_SHOE, "shoe");
      drive(180, 5, 1'b1, C_GRASS, "shoe_transp");
      drive(300, 22, 1'b1, C_POTION, "potion");
      drive(700, 50, 1'b1, 24'h0, "oom_x");
      drive(100, 480, 1'b1, 24'h0, "oom_y");
      drive(85, 50, 1'b0, 24'h0, "invalid");

      map_a[18] = 4'd2;
      drive(85, 55, 1'b1, C_BRICK, "map_change");
      map_a[18] = 4'd1;
      drive(85, 55, 1'b1, C_BOX, "map_restore");

      player_X[0] = 10'd100; player_Y[0] = 10'd100;
      player_X[1] = 10'd100; player_Y[1] = 10'd100;
      player_alive = 2'b11;
      drive(100, 100, 1'b1, C_P0, "p0_over_p1");
      drive(86, 100, 1'b1, C_P1, "p1_through_hole");
      drive(80, 100, 1'b1, C_GRASS, "p_border");
      player_alive = 2'b10;
      drive(100, 100, 1'b1, C_P1, "p0_dead");

      player_X[0] = 10'd10;
      player_alive = 2'b01;
      drive(0, 110, 1'b1, C_P0, "win_left");
      drive(29, 110, 1'b1, C_GRASS, "win_edge");
      drive(30, 110, 1'b1, C_GRASS, "win_right");
      player_X[1] = 10'd645;
      player_alive = 2'b11;
      drive(645, 100, 1'b1, 24'h0, "p_oom");
      player_alive = 2'b01;

      player_blink = 2'b01;
      repeat (8) pulse();
      chk("fc8", 32'(frame_cnt), 32'd8);
`ifdef PLAYER_BLINK_EN
      drive(0, 110, 1'b1, C_GRASS, "blink_off");
`else
      drive(0, 110, 1'b1, C_P0, "blink_ignored");
`endif
      repeat (8) pulse();
      chk("fc16", 32'(frame_cnt), 32'd16);
      drive(0, 110, 1'b1, C_P0, "blink_on");
      repeat (47) pulse();
      chk("fc63", 32'(frame_cnt), 32'd63);
      pulse();
      chk("fc_wrap", 32'(frame_cnt), 32'd0);
      pulse();

      idle(4);
      chk("drain", 32'(sb.size()), 32'd0);

      mon_en       = 1'b0;
      player_alive = 2'b00;
      DrawX        = 10'd85;
      DrawY        = 10'd50;
      pix_valid_in = 1'b1;
      repeat (3) begin
         @(posedge Clk); #1;
      end
      chk("pre_rst_vld", 32'(pix_valid_out), 32'd1);
      chk("pre_rst_rgb", {8'h00, Red, Green, Blue}, {8'h00, C_BOX});
      Reset = 1'b0;
      @(posedge Clk); #1;
      chk("mid_rst_vld", 32'(pix_valid_out), 32'd0);
      chk("mid_rst_rgb", {8'h00, Red, Green, Blue}, 32'd0);
      chk("mid_rst_fc", 32'(frame_cnt), 32'd0);
      Reset = 1'b1;
      repeat (2) begin
         @(posedge Clk); #1;
         chk("refill_vld", 32'(pix_valid_out), 32'd0);
      end
      @(posedge Clk); #1;
      chk("refill_first_vld", 32'(pix_valid_out), 32'd1);
      chk("refill_first_rgb", {8'h00, Red, Green, Blue}, {8'h00, C_BOX});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipelined_color_mapper.md
# pipelined_color_mapper

Parametrised, pipelined successor to the combinational pixel colour mapper. It maps each (DrawX, DrawY) to RGB by compositing the tile layer (map_array), the treasure layer (treasure_array) and N player sprites with transparency. Registered stages and a valid pipeline give a fixed latency, which closes timing at pixel clock. A frame counter adds player blink (invincibility) behaviour. It sits between the VGA controller / game logic and the DAC outputs.

## Interface
- TILE, 40: tile edge in pixels; sprite ROMs address 0..TILE-1.
- MAP_COLS, 16: tiles per row.
- MAP_ROWS, 12: tile rows.
- NUM_PLAYERS, 2: player sprites, 1..4.
- HALF, 20: player window half-size in pixels.

Ports:
- Clk  in  1  pixel clock; the only clock.
- Reset  in  1  synchronous, active-low reset.
- pix_valid_in  in  1  DrawX/DrawY valid this cycle.
- DrawX, DrawY  in  10 each  pixel coordinate.
- frame_start  in  1  one-cycle pulse per frame.
- player_X, player_Y  in  [NUM_PLAYERS-1:0][9:0]  player centres.
- player_alive  in  NUM_PLAYERS  player drawn only when set.
- player_blink  in  NUM_PLAYERS  request blink for that player.
- map_array  in  [0:MAP_COLS*MAP_ROWS-1][3:0]  tile codes: 0 grass, 1 box, 2 brick, 3 bomb, 4 explosion.
- treasure_array  in  same  5 shoe, 6 potion, else none.
- pix_valid_out  out  1  RGB valid.
- Red, Green, Blue  out  8 each  pixel colour.
- frame_cnt  out  6  frames since reset, wraps.

## Operation
- S1 (register): tile column/row = DrawX/TILE, DrawY/TILE; local offsets = DrawX%TILE, DrawY%TILE. Per player, hit_p is set when DrawX-X+HALF ∈ [0,2·HALF) and likewise for Y. The comparison is 11-bit signed, so no underflow when X<HALF. Sprite offset = DrawX-X+HALF.
- S2 (register): fetch the sprite_index and treasure_index. Look up the 5-bit colour from the grass/box/brick/bomb/explosion/shoe/potion/player ROMs. 5'hf means transparent.
- S3 (register): priority select, then colortable lookup to RGB.
- Priority, highest first:
  - Player p (lowest index wins) when hit_p, player_alive[p], pixel not 5'hf, and not blanked.
  - Tile 1/2/4: opaque box/brick/explosion.
  - Tile 3: bomb pixel, or grass if the bomb pixel is transparent.
  - Tile 0 with treasure 5/6: shoe/potion pixel, or grass if transparent.
  - Otherwise grass.
- Out-of-map pixels (col ≥ MAP_COLS or row ≥ MAP_ROWS) → RGB 0; players are not drawn there.
- frame_cnt: increments on frame_start and wraps 63→0.
- Blank: player p is blanked when player_blink[p] && frame_cnt[3] (8-frame on/off).
- pix_valid_in=0: the stage still computes, but pix_valid_out=0 and RGB=0 for that slot.

## Timing
- Latency is exactly 3 cycles from pix_valid_in/DrawX to pix_valid_out/RGB. Throughput is 1 pixel per cycle with no stalls.
- Reset values: pix_valid_out=0, Red=Green=Blue=0, frame_cnt=0, all pipeline valid bits cleared.
- Reset asserted mid-frame: outputs go to zero on the next edge, and the pipeline refills from scratch 3 cycles after release.
- frame_start coinciding with a pixel: the counter updates at that edge. Blank is sampled in S1, so a pixel in flight uses the old frame_cnt value.
- player_X/Y, map_array and treasure_array are sampled in S1 only. Changes apply to pixels entering after the change.

## Configuration
- PLAYER_BLINK_EN defined: blink blanking as above.
- PLAYER_BLINK_EN undefined: player_blink is ignored, players are always drawn when alive, and frame_cnt still counts.

## Test plan
- Reset=0 for 2 cycles with pix_valid_in=1 → pix_valid_out=0 and RGB=0. Release → first valid output exactly 3 cycles after the first sampled pixel.
- map_array all 0, tile (2,1)=1, DrawX=85, DrawY=50 → box colour. DrawX=125 → grass colour.
- Tile (0,0)=3, bomb ROM transparent at offset (0,0) → DrawX=0, DrawY=0 gives grass. An opaque bomb offset gives the bomb colour.
- P0 and P1 both at (100,100), both alive → P0 colour where its pixel is opaque. Where P0 is 5'hf and P1 is opaque → P1 colour.
- player_X=10 (window -10..29), DrawX=0 → hit, no underflow. DrawX=30 → tile colour.
- With PLAYER_BLINK_EN, player_blink[0]=1, 8 frame_start pulses → frame_cnt=8 and P0 becomes invisible (tile shown). After 16 pulses → P0 visible again.
